// File: rtl/led_pwm_fader.sv
// ---------------------------------------------------------------------------
// led_pwm_fader
//
// Turns the blinker's 1-bit on/off request into a linear brightness ramp and
// drives the LED pin through a free-running PWM dimmer. A rise of the request
// ramps the brightness up to MAX one LSB every STEP_CYCLES clocks; a fall
// ramps it back down to 0. A reversal mid-ramp turns the ramp around from the
// current level.
//
// Parameters:
//   PWM_BITS     brightness / PWM counter width, MAX = 2**PWM_BITS - 1
//   STEP_CYCLES  clocks per one-LSB brightness step
//
// Ports:
//   CLK100MHZ  in   board clock, all logic on its rising edge
//   RST        in   synchronous active-high reset
//   led_req    in   target from the blinker: 1 = fade to MAX, 0 = fade to 0
//   LED        out  registered PWM output to the pin
//   level      out  current brightness
//   busy       out  high while ramping (UP or DOWN)
//
// Build option:
//   LED_PWM_GAMMA_EN  when defined, the PWM compare value is
//                     (level*level) >> PWM_BITS, registered, giving a
//                     perceptually linear fade at one extra cycle of latency.
//                     When undefined, the compare value is level itself.
// ---------------------------------------------------------------------------
module led_pwm_fader #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 97656
) (
    input  logic                CLK100MHZ,
    input  logic                RST,
    input  logic                led_req,
    output logic                LED,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [TW-1:0]       STEP_LAST = TW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PWM_BITS-1:0] level_next;
    logic [TW-1:0]       step_cnt;
    logic [TW-1:0]       step_next;
    logic                tick;
    logic                req_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] cmp;

    // Saturating one-LSB steps: the level never wraps at either end.
    function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] v);
        return (v == MAX) ? MAX : v + PWM_BITS'(1);
    endfunction

    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] v);
        return (v == '0) ? '0 : v - PWM_BITS'(1);
    endfunction

    // Upper half of level squared: a cheap gamma-2 approximation.
    function automatic logic [PWM_BITS-1:0] gamma_sq(input logic [PWM_BITS-1:0] v);
        logic [2*PWM_BITS-1:0] p;
        p = {{PWM_BITS{1'b0}}, v} * {{PWM_BITS{1'b0}}, v};
        return p[2*PWM_BITS-1:PWM_BITS];
    endfunction

    // The step timer only runs while ramping, so tick is gated by state.
    assign tick = (step_cnt == STEP_LAST) && (state == UP || state == DOWN);

    always_comb begin
        state_next = state;
        level_next = level;
        case (state)
            OFF: begin
                level_next = '0;
                if (req_q) state_next = UP;
            end
            UP: begin
                // A direction change wins over a coincident tick.
                if (!req_q) begin
                    state_next = DOWN;
                end else if (tick) begin
                    level_next = sat_inc(level);
                    if (level_next == MAX) state_next = ON;
                end
            end
            ON: begin
                level_next = MAX;
                if (!req_q) state_next = DOWN;
            end
            DOWN: begin
                if (req_q) begin
                    state_next = UP;
                end else if (tick) begin
                    level_next = sat_dec(level);
                    if (level_next == '0) state_next = OFF;
                end
            end
            default: begin
                state_next = OFF;
                level_next = '0;
            end
        endcase

        // Timer restarts on every state change so each ramp segment gets a
        // full STEP_CYCLES before its first step; it idles at 0 when settled.
        if (state_next != state || state_next == OFF || state_next == ON || tick) begin
            step_next = '0;
        end else begin
            step_next = step_cnt + TW'(1);
        end
    end

`ifdef LED_PWM_GAMMA_EN
    logic [PWM_BITS-1:0] cmp_p1;

    // Stage 1: registered gamma-corrected compare value.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            cmp_p1 <= '0;
        end else begin
            cmp_p1 <= gamma_sq(level);
        end
    end

    assign cmp = cmp_p1;
`else
    assign cmp = level;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            req_q    <= 1'b0;
            state    <= OFF;
            level    <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            pwm_cnt  <= '0;
            LED      <= 1'b0;
        end else begin
            req_q    <= led_req;
            state    <= state_next;
            level    <= level_next;
            step_cnt <= step_next;
            busy     <= (state_next == UP) || (state_next == DOWN);
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            // Strict less-than: MAX gives MAX/(MAX+1) duty, never fully on.
            LED      <= (pwm_cnt < cmp);
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
module tb_led_pwm_fader;

    localparam int PB = 4;
    localparam int SC = 4;

`ifdef LED_PWM_GAMMA_EN
    localparam int EXP_ON = 14;
    localparam int EXP_L3 = 0;
    localparam int EXP_L8 = 4;
`else
    localparam int EXP_ON = 15;
    localparam int EXP_L3 = 3;
    localparam int EXP_L8 = 8;
`endif

    logic          clk = 1'b0;
    logic          RST;
    logic          led_req;
    logic          LED;
    logic [PB-1:0] level;
    logic          busy;

    always #5 clk = ~clk;

    led_pwm_fader #(
        .PWM_BITS   (PB),
        .STEP_CYCLES(SC)
    ) dut (
        .CLK100MHZ(clk),
        .RST      (RST),
        .led_req  (led_req),
        .LED      (LED),
        .level    (level),
        .busy     (busy)
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sig: 0 level, 1 busy, 2 LED, 3 internal PWM counter
    function automatic logic [31:0] sample(input int sig);
        case (sig)
            0:       return 32'(level);
            1:       return 32'(busy);
            2:       return 32'(LED);
            3:       return 32'(dut.pwm_cnt);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic test_reset();
        exp_t e;
        RST     = 1'b1;
        led_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            sbq.push_back('{c, 0, 0, "rst_level"});
            sbq.push_back('{c, 1, 0, "rst_busy"});
            sbq.push_back('{c, 2, 0, "rst_led"});
        end
        sbq.push_back('{3, 3, 0, "rst_pwm_cnt"});
        for (int c = 1; c <= 3; c++) begin
            led_req = ~led_req;
            step();
            while (sbq.size() > 0 && sbq[0].cyc == c) begin
                e = sbq.pop_front();
                n_checks++;
                if (sample(e.sig) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
                end
            end
        end
        RST     = 1'b0;
        led_req = 1'b0;
        sbq.push_back('{1, 3, 1, "rel_pwm_cnt"});
        sbq.push_back('{1, 0, 0, "rel_level"});
        sbq.push_back('{1, 1, 0, "rel_busy"});
        step();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_checks++;
            if (sample(e.sig) !== e.exp) begin
                n_fail++;
                $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
            end
        end
    endtask

    task automatic test_full_ramp();
        exp_t e;
        led_req = 1'b1;
        sbq.push_back('{1,  1, 0,  "ramp_busy_e1"});
        sbq.push_back('{2,  1, 1,  "ramp_busy_e2"});
        sbq.push_back('{5,  0, 0,  "ramp_level_e5"});
        sbq.push_back('{6,  0, 1,  "ramp_level_e6"});
        sbq.push_back('{10, 0, 2,  "ramp_level_e10"});
        sbq.push_back('{61, 0, 14, "ramp_level_e61"});
        sbq.push_back('{61, 1, 1,  "ramp_busy_e61"});
        sbq.push_back('{62, 0, 15, "ramp_level_e62"});
        sbq.push_back('{62, 1, 0,  "ramp_busy_e62"});
        sbq.push_back('{80, 0, 15, "ramp_level_hold"});
        sbq.push_back('{80, 1, 0,  "ramp_busy_hold"});
        for (int c = 1; c <= 80; c++) begin
            step();
            while (sbq.size() > 0 && sbq[0].cyc == c) begin
                e = sbq.pop_front();
                n_checks++;
                if (sample(e.sig) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
                end
            end
        end
    endtask

    task automatic test_duty();
        exp_t e;
        int   cnt;
        for (int p = 0; p < 2; p++) begin
            sbq.push_back('{0, 2, EXP_ON, "duty_on_period"});
            cnt = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                cnt += int'(LED);
            end
            e = sbq.pop_front();
            n_checks++;
            if (32'(cnt) !== e.exp) begin
                n_fail++;
                $display("FAIL %s: observed %0d high cycles, expected %0d", e.name, cnt, e.exp);
            end
        end
        led_req = 1'b0;
        sbq.push_back('{70, 0, 0, "duty_fall_level"});
        sbq.push_back('{70, 1, 0, "duty_fall_busy"});
        for (int c = 1; c <= 70; c++) begin
            step();
            while (sbq.size() > 0 && sbq[0].cyc == c) begin
                e = sbq.pop_front();
                n_checks++;
                if (sample(e.sig) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
                end
            end
        end
        sbq.push_back('{0, 2, 0, "duty_off"});
        cnt = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            cnt += int'(LED);
        end
        e = sbq.pop_front();
        n_checks++;
        if (32'(cnt) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d high cycles, expected %0d", e.name, cnt, e.exp);
        end
    endtask

    task automatic test_reversal();
        exp_t e;
        bit   ok;
        led_req = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (level == 4'd7) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rev_wait_level7: level=%0d, expected 7 within 100 cycles", level);
        end
        led_req = 1'b0;
        sbq.push_back('{3,  0, 7, "rev_level_e3"});
        sbq.push_back('{5,  0, 7, "rev_level_e5"});
        sbq.push_back('{6,  0, 6, "rev_level_e6"});
        sbq.push_back('{29, 0, 1, "rev_level_e29"});
        sbq.push_back('{29, 1, 1, "rev_busy_e29"});
        sbq.push_back('{30, 0, 0, "rev_level_e30"});
        sbq.push_back('{30, 1, 0, "rev_busy_e30"});
        sbq.push_back('{50, 0, 0, "rev_no_wrap"});
        for (int c = 1; c <= 50; c++) begin
            step();
            while (sbq.size() > 0 && sbq[0].cyc == c) begin
                e = sbq.pop_front();
                n_checks++;
                if (sample(e.sig) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        exp_t e;
        bit   ok;
        led_req = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (level == 4'd5) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_wait_level5: level=%0d, expected 5 within 100 cycles", level);
        end
        RST = 1'b1;
        sbq.push_back('{1, 0, 0, "mid_rst_level"});
        sbq.push_back('{1, 1, 0, "mid_rst_busy"});
        sbq.push_back('{1, 2, 0, "mid_rst_led"});
        sbq.push_back('{2, 0, 0, "mid_rst_level_e2"});
        for (int c = 1; c <= 2; c++) begin
            step();
            while (sbq.size() > 0 && sbq[0].cyc == c) begin
                e = sbq.pop_front();
                n_checks++;
                if (sample(e.sig) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
                end
            end
        end
        RST = 1'b0;
        sbq.push_back('{1, 1, 0, "restart_busy_d1"});
        sbq.push_back('{2, 1, 1, "restart_busy_d2"});
        sbq.push_back('{2, 0, 0, "restart_level_d2"});
        sbq.push_back('{5, 0, 0, "restart_level_d5"});
        sbq.push_back('{6, 0, 1, "restart_level_d6"});
        for (int c = 1; c <= 6; c++) begin
            step();
            while (sbq.size() > 0 && sbq[0].cyc == c) begin
                e = sbq.pop_front();
                n_checks++;
                if (sample(e.sig) !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
                end
            end
        end
        led_req = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (level == 4'd0 && busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_wait_off: level=%0d busy=%0d, expected 0/0 within 100 cycles", level, busy);
        end
    endtask

    // Toggling the request every two cycles keeps flipping UP/DOWN, which
    // keeps clearing the step timer, so the level is held for a duty count.
    task automatic test_frozen_duty();
        exp_t e;
        bit   ok;
        int   cnt;
        int   tgt [2];
        int   expd [2];
        tgt[0]  = 3;
        tgt[1]  = 8;
        expd[0] = EXP_L3;
        expd[1] = EXP_L8;
        led_req = 1'b1;
        for (int t = 0; t < 2; t++) begin
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                step();
                if (int'(level) == tgt[t]) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL frozen_wait_level: level=%0d, expected %0d within 100 cycles", level, tgt[t]);
            end
            sbq.push_back('{0, 2, expd[t], "frozen_duty"});
            sbq.push_back('{0, 0, tgt[t],  "frozen_level"});
            cnt = 0;
            for (int c = 0; c < 24; c++) begin
                if (c % 2 == 0) led_req = ~led_req;
                step();
                if (c >= 8) cnt += int'(LED);
            end
            e = sbq.pop_front();
            n_checks++;
            if (32'(cnt) !== e.exp) begin
                n_fail++;
                $display("FAIL %s: observed %0d high cycles, expected %0d", e.name, cnt, e.exp);
            end
            e = sbq.pop_front();
            n_checks++;
            if (sample(e.sig) !== e.exp) begin
                n_fail++;
                $display("FAIL %s: observed %0d, expected %0d", e.name, sample(e.sig), e.exp);
            end
        end
        led_req = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (level == 4'd0 && busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL frozen_wait_off: level=%0d busy=%0d, expected 0/0 within 100 cycles", level, busy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST     = 1'b1;
        led_req = 1'b0;
        test_reset();
        test_full_ramp();
        test_duty();
        test_reversal();
        test_reset_mid_ramp();
        test_frozen_duty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
